regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//   Parametrised successor to the single-cycle CPU register file: N combinational read
//   ports, 1 write port, hardwired zero register, async reset and a sequential clear engine.
//   Sits in the datapath between decode (read addresses) and writeback (RW/BusW/RegWr).
//   Storage updates on negedge Clk, so a value written in cycle N is readable in cycle N+1.
// PARAMETERS
//   DATA_WIDTH  64  width of each register and of BusW/each read bus
//   ADDR_WIDTH   5  register address width; DEPTH = 2**ADDR_WIDTH entries
//   NUM_READ     2  number of independent read ports (>=1)
//   ZERO_REG    31  index hardwired to zero: reads 0, writes discarded
// PORTS
//   Clk     in   1                      clock; all state updates on negedge Clk
//   Reset   in   1                      asynchronous, active-high reset
//   Clear   in   1                      request full-array clear (sampled at negedge Clk)
//   RegWr   in   1                      write enable
//   RW      in   ADDR_WIDTH             write address
//   BusW    in   DATA_WIDTH             write data
//   RA      in   NUM_READ*ADDR_WIDTH    read addresses; port k = RA[k*ADDR_WIDTH +: ADDR_WIDTH]
//   BusR    out  NUM_READ*DATA_WIDTH    read data; port k = BusR[k*DATA_WIDTH +: DATA_WIDTH]
//   Ready   out  1                      1 = array valid, reads/writes live
// BEHAVIOUR
//   - Reset asserted: state=CLEAR, clr_idx=0, Ready=0 immediately (async); array not touched.
//   - FSM states: CLEAR, READY.
//     CLEAR: each negedge writes 0 to mem[clr_idx], clr_idx++. At clr_idx==DEPTH-1 the
//       write completes and state->READY, Ready=1. Exactly DEPTH negedges after reset release.
//     READY: Clear=1 at negedge -> CLEAR, clr_idx=0, Ready=0; the current write is dropped.
//     Clear=1 during CLEAR restarts clr_idx at 0 (clear always completes a full pass).
//   - Reset mid-clear: restarts from clr_idx=0, Ready held 0.
//   - Writes: in READY, at negedge with RegWr=1 and RW!=ZERO_REG, mem[RW]<=BusW.
//     RegWr while Ready=0 is ignored (no queueing). Writes to ZERO_REG are always discarded.
//   - Reads: combinational, zero latency. Port k returns 0 if Ready=0 or RA_k==ZERO_REG,
//     else mem[RA_k]. All ports may address the same register simultaneously.
//   - Read/write same address, same cycle: see CONFIGURATION.
//   - clr_idx is ADDR_WIDTH bits; terminal compare on DEPTH-1, no wrap past it.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: in READY, if RegWr=1, RW!=ZERO_REG and RA_k==RW, BusR_k=BusW
//     combinationally (write-before-read forwarding within the cycle, pre-negedge).
//   Not defined: BusR_k shows the old mem[RA_k] until the negedge write lands.
//   The Ready=0 and ZERO_REG rules take priority over the bypass in both builds.
// TESTING
//   1 Reset pulse, release; count negedges -> Ready=0 for exactly 32 negedges (defaults),
//     then 1; all ports read 0.
//   2 READY: write R5=64'hDEAD_BEEF_0000_0001; next cycle RA0=5, RA1=5 -> both ports read
//     64'hDEAD_BEEF_0000_0001.
//   3 Write R31=64'hFFFF..FF, then RA0=31 -> 0; R30 unchanged.
//   4 Same cycle RegWr=1, RW=7, BusW=64'h1234, RA0=7 (R7 holds 64'h0) -> pre-negedge BusR0
//     =64'h1234 with REGFILE_BYPASS_EN, 64'h0 without; post-negedge 64'h1234 in both.
//   5 Load R1..R3 with nonzero values, assert Clear + RegWr (RW=4) at the same negedge
//     -> Ready=0, R4 not written; after 32 negedges Ready=1, R1..R4 read 0.
//   6 Assert Reset at clear step 10 -> Ready stays 0, clear restarts; Ready=1 32 negedges
//     after release; RegWr pulses during clear have no effect.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file with NUM_READ combinational read ports,
// one write port, a hardwired zero register and a sequential clear engine.
//
// All state updates on the falling edge of Clk, so a value written in cycle N is
// readable in cycle N+1. After reset (or a Clear request) the engine zeroes one entry
// per falling edge; Ready rises once every entry has been cleared.
//
// Ports:
//   Clk    in   1                    clock; state updates on negedge
//   Reset  in   1                    asynchronous active-high reset
//   Clear  in   1                    request full-array clear (sampled at negedge)
//   RegWr  in   1                    write enable
//   RW     in   ADDR_WIDTH           write address
//   BusW   in   DATA_WIDTH           write data
//   RA     in   NUM_READ*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   BusR   out  NUM_READ*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Ready  out  1                    array valid, reads/writes live
//
// Build option: define REGFILE_BYPASS_EN to forward BusW to any read port addressing RW
// in the same cycle a write is pending.
module regfile_multiport #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Clear,
  input  logic                           RegWr,
  input  logic [ADDR_WIDTH-1:0]          RW,
  input  logic [DATA_WIDTH-1:0]          BusW,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] RA,
  output logic [NUM_READ*DATA_WIDTH-1:0] BusR,
  output logic                           Ready
);

  localparam int unsigned           Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(Depth - 1);
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic                    clr_we;
  logic                    wr_en;

  // State register.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic. The index parks on LastIdx once the pass completes.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        if (Clear) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LastIdx) begin
          state_d = StReady;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      StReady: begin
        if (Clear) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = StClear;
        clr_idx_d = '0;
      end
    endcase
  end

  // Outputs and array strobes. A write coinciding with Clear is dropped.
  always_comb begin
    Ready  = (state_q == StReady);
    clr_we = (state_q == StClear);
    wr_en  = (state_q == StReady) && RegWr && !Clear && (RW != ZeroAddr);
  end

  // Storage has no reset. Held reset repeatedly zeroes entry 0, which the following
  // clear pass would zero anyway, so no reset gating is needed here.
  always_ff @(negedge Clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_en) begin
      mem[RW] <= BusW;
    end
  end

  // Read ports: not-ready and zero-register rules win over forwarding.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = RA[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = '0;
      if (!Ready || (ra == ZeroAddr)) begin
        rd = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (RegWr && (RW != ZeroAddr) && (ra == RW)) begin
        rd = BusW;
`endif
      end else begin
        rd = mem[ra];
      end
    end

    assign BusR[k*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (default parameters). Stimulus is applied 1ns
// after each falling edge and pushes expected values; the monitor drains the queue on
// the following rising edge, between updates.
module tb_regfile_multiport;

  logic         Clk;
  logic         Reset;
  logic         Clear;
  logic         RegWr;
  logic [4:0]   RW;
  logic [63:0]  BusW;
  logic [9:0]   RA;
  logic [127:0] BusR;
  logic         Ready;

  int n_cmp;
  int n_fail;

  typedef struct {
    string       name;
    bit          is_ready;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  regfile_multiport dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Clear),
    .RegWr (RegWr),
    .RW    (RW),
    .BusW  (BusW),
    .RA    (RA),
    .BusR  (BusR),
    .Ready (Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog: stimulus is fixed-length, so this only fires if the simulator stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary / required summary");
    $fatal(1, "timeout");
  end

  // Monitor: compare every queued expectation at the rising edge.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(posedge Clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.is_ready ? {63'b0, Ready} : BusR[e.port*64 +: 64];
        n_cmp++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h required %h (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic exp_ready(input string name, input logic v);
    exp_t e;
    e.name = name; e.is_ready = 1'b1; e.port = 0; e.exp = {63'b0, v};
    sb.push_back(e);
  endtask

  task automatic exp_rd(input string name, input int port, input logic [63:0] v);
    exp_t e;
    e.name = name; e.is_ready = 1'b0; e.port = port; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    RA = {a1, a0};
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
    RegWr = 1'b1; RW = a; BusW = d;
    step();
    RegWr = 1'b0;
  endtask

  initial begin
    logic [63:0] bypass_exp;
    n_cmp  = 0;
    n_fail = 0;
    Reset  = 1'b1;
    Clear  = 1'b0;
    RegWr  = 1'b0;
    RW     = '0;
    BusW   = '0;
    RA     = '0;

    // 1: reset release, Ready after exactly 32 falling edges, reads 0 throughout.
    step();
    step();
    Reset = 1'b0;
    set_ra(5'd3, 5'd0);
    exp_ready("rst_ready_pre", 1'b0);
    exp_rd("rst_rd0_pre", 0, 64'h0);
    exp_rd("rst_rd1_pre", 1, 64'h0);
    for (int i = 1; i <= 32; i++) begin
      step();
      exp_ready($sformatf("rst_ready_n%0d", i), (i == 32));
    end
    exp_rd("rst_rd0_post", 0, 64'h0);
    exp_rd("rst_rd1_post", 1, 64'h0);

    // 2: write R5, read it on both ports next cycle.
    step();
    write_reg(5'd5, 64'hDEAD_BEEF_0000_0001);
    set_ra(5'd5, 5'd5);
    exp_rd("r5_port0", 0, 64'hDEAD_BEEF_0000_0001);
    exp_rd("r5_port1", 1, 64'hDEAD_BEEF_0000_0001);

    // 3: zero register discards writes and reads 0, even while a write to it is pending.
    step();
    write_reg(5'd30, 64'h30);
    RegWr = 1'b1; RW = 5'd31; BusW = '1;
    set_ra(5'd31, 5'd30);
    exp_rd("r31_pending", 0, 64'h0);
    step();
    RegWr = 1'b0;
    exp_rd("r31_after", 0, 64'h0);
    exp_rd("r30_unchanged", 1, 64'h30);

    // 4: same-cycle read/write of R7.
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 64'h1234;
`else
    bypass_exp = 64'h0;
`endif
    step();
    RegWr = 1'b1; RW = 5'd7; BusW = 64'h1234;
    set_ra(5'd7, 5'd8);
    exp_rd("r7_pre_negedge", 0, bypass_exp);
    exp_rd("r8_untouched", 1, 64'h0);
    step();
    RegWr = 1'b0;
    exp_rd("r7_post_negedge", 0, 64'h1234);

    // 5: Clear together with a write to R4; write dropped, full pass follows.
    step();
    write_reg(5'd1, 64'h11);
    write_reg(5'd2, 64'h22);
    write_reg(5'd3, 64'h33);
    set_ra(5'd1, 5'd3);
    Clear = 1'b1; RegWr = 1'b1; RW = 5'd4; BusW = 64'h44;
    exp_rd("r1_before_clear", 0, 64'h11);
    exp_rd("r3_before_clear", 1, 64'h33);
    exp_ready("ready_before_clear", 1'b1);
    step();
    Clear = 1'b0; RegWr = 1'b0;
    exp_ready("clr_ready_drop", 1'b0);
    exp_rd("clr_rd_gated", 0, 64'h0);
    for (int i = 1; i <= 32; i++) begin
      step();
      exp_ready($sformatf("clr_ready_n%0d", i), (i == 32));
    end
    set_ra(5'd1, 5'd2);
    exp_rd("clr_r1", 0, 64'h0);
    exp_rd("clr_r2", 1, 64'h0);
    step();
    set_ra(5'd3, 5'd4);
    exp_rd("clr_r3", 0, 64'h0);
    exp_rd("clr_r4", 1, 64'h0);

    // 6: Reset at clear step 10; writes attempted throughout the clear are ignored.
    step();
    write_reg(5'd9, 64'h99);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    RegWr = 1'b1; RW = 5'd9; BusW = 64'hABCD;
    Reset = 1'b1;
    #1;
    exp_ready("mid_reset_ready", 1'b0);
    step();
    Reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      exp_ready($sformatf("rst2_ready_n%0d", i), (i == 32));
      if (i == 32) RegWr = 1'b0;
    end
    set_ra(5'd9, 5'd5);
    exp_rd("rst2_r9", 0, 64'h0);
    exp_rd("rst2_r5", 1, 64'h0);

    // Let the monitor drain the queue.
    step();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
